// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - drains a fixed-length burst from a sync_fifo onto a valid/ready stream
//
// Purpose:
//   Owns the FIFO read strobe, absorbs the FIFO's one-cycle read latency in a
//   small circular buffer and presents the words in order to a downstream
//   consumer. Reads are only issued against free buffer credit, so downstream
//   backpressure can never cause a returned word to be lost.
//
// Ports:
//   clk        - system clock, all state on rising edge
//   sys_rst_n  - synchronous active-low reset
//   start      - one-cycle burst request, honoured only in IDLE
//   burst_len  - number of words to read, sampled with start
//   fifo_empty - FIFO empty flag
//   fifo_data  - FIFO data_out, valid the cycle after fifo_rd_en
//   fifo_rd_en - FIFO read strobe
//   out_data   - head word of the buffer, zero when out_valid is low
//   out_valid  - out_data holds a word
//   out_ready  - downstream accepts on out_valid & out_ready
//   busy       - burst in progress (READ or DRAIN)
//   done       - one-cycle pulse after the last word is accepted

module fifo_burst_reader #(
  parameter int RSA_DW    = 8,
  parameter int LEN_W     = 8,
  parameter int BUF_DEPTH = 4,
  parameter int BUF_AW    = 2
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              fifo_empty,
  input  logic [RSA_DW-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic [RSA_DW-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [BUF_AW+1:0] DEPTH_C = (BUF_AW+2)'(BUF_DEPTH);

  state_t             state;
  state_t             state_nxt;
  logic [LEN_W-1:0]   remaining;
  logic [LEN_W-1:0]   remaining_nxt;
  logic               rd_pend;
  logic [BUF_AW:0]    occ;
  logic [BUF_AW:0]    occ_nxt;
  logic [BUF_AW-1:0]  wr_ptr;
  logic [BUF_AW-1:0]  rd_ptr;
  logic [RSA_DW-1:0]  buf_mem [BUF_DEPTH];
  logic               capture;
  logic               pop;
  logic               rd_en;
  logic [BUF_AW+1:0]  credit_used;

  // A word returns exactly one cycle after every read strobe.
  assign capture = rd_pend;
  assign pop     = out_valid & out_ready;

  // Words already in the buffer plus the one in flight from the FIFO; a new
  // read is only allowed while this leaves a free slot.
  assign credit_used = {1'b0, occ} + (BUF_AW+2)'(rd_pend);

  always_comb begin
    occ_nxt = occ;
    case ({capture, pop})
      2'b10:   occ_nxt = occ + 1'b1;
      2'b01:   occ_nxt = occ - 1'b1;
      default: occ_nxt = occ;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    rd_en         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          remaining_nxt = burst_len;
          state_nxt     = (burst_len != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        rd_en = !fifo_empty && (remaining != '0) && (credit_used < DEPTH_C);
        if (rd_en) begin
          remaining_nxt = remaining - 1'b1;
        end
        if (remaining_nxt == '0) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave as soon as the buffer empties on this cycle's pop, so done
        // lands in the cycle right after the final acceptance.
        if (!rd_pend && (occ_nxt == '0)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      state     <= S_IDLE;
      remaining <= '0;
      rd_pend   <= 1'b0;
      occ       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      rd_pend   <= rd_en;
      occ       <= occ_nxt;
      if (capture) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage only; validity is tracked by occ, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (sys_rst_n && capture) begin
      buf_mem[wr_ptr] <= fifo_data;
    end
  end

  assign fifo_rd_en = rd_en;
  assign out_valid  = (occ != '0);
  assign out_data   = out_valid ? buf_mem[rd_ptr] : '0;
  assign busy       = (state == S_READ) || (state == S_DRAIN);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - scoreboard bench for fifo_burst_reader

module tb_fifo_burst_reader;

  localparam int RSA_DW    = 8;
  localparam int LEN_W     = 8;
  localparam int BUF_DEPTH = 4;
  localparam int BUF_AW    = 2;

  logic              clk = 1'b0;
  logic              sys_rst_n;
  logic              start;
  logic [LEN_W-1:0]  burst_len;
  logic              fifo_empty;
  logic [RSA_DW-1:0] fifo_data = '0;
  logic              fifo_rd_en;
  logic [RSA_DW-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  int checks   = 0;
  int fails    = 0;
  int rd_cnt   = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;
  int ready_mode = 0;
  int pat_ph     = 0;
  logic rd_en_s  = 1'b0;

  logic [RSA_DW-1:0] fq[$];
  logic [RSA_DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .RSA_DW(RSA_DW), .LEN_W(LEN_W), .BUF_DEPTH(BUF_DEPTH), .BUF_AW(BUF_AW)
  ) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .start(start), .burst_len(burst_len),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // FIFO model: one-cycle read latency; garbage on data_out when not read.
  always @(posedge clk) begin
    if (rd_en_s) begin
      rd_cnt++;
      if (fq.size() != 0) fifo_data <= fq.pop_front();
      else fifo_data <= 8'hEE;
    end else begin
      fifo_data <= 8'($urandom);
    end
  end

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    rd_en_s = fifo_rd_en;
    if (sys_rst_n) begin
      if (fifo_rd_en) chk("rd_en_while_empty", fifo_empty, 0);
      chk("credit_bound", 32'((rd_cnt - acc_cnt) <= BUF_DEPTH), 1);
      if (!out_valid) chk("data_zero_when_invalid", out_data, 0);
      if (out_valid && out_ready) begin
        chk("word_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("out_data_order", out_data, exp_q.pop_front());
        acc_cnt++;
      end
      if (done) begin
        done_cnt++;
        chk("busy_low_in_done", busy, 0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    fifo_empty = (fq.size() == 0);
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = (pat_ph == 0);
        pat_ph = (pat_ph + 1) % 3;
      end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic push(input logic [RSA_DW-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic run_burst(input int len, input int pre, input int stall, input int restart_at);
    int pushed = 0;
    int d0;
    bit seen = 0;
    for (int i = 0; i < pre; i++) begin
      push(8'($urandom));
      pushed++;
    end
    d0 = done_cnt;
    start = 1'b1;
    burst_len = LEN_W'(len);
    for (int k = 1; k <= 3000 && !seen; k++) begin
      cyc();
      start = (k == restart_at);
      if (start) burst_len = LEN_W'($urandom_range(1, 255));
      if (k > stall && pushed < len && $urandom_range(0, 3) != 0) begin
        push(8'($urandom));
        pushed++;
      end
      if (done) seen = 1;
    end
    start = 1'b0;
    chk("done_within_budget", 32'(seen), 1);
    cyc();
    chk("done_single_cycle", done, 0);
    chk("done_count", 32'(done_cnt - d0), 1);
    chk("all_words_delivered", 32'(exp_q.size()), 0);
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n  = 1'b0;
    start      = 1'b0;
    burst_len  = '0;
    out_ready  = 1'b1;
    fifo_empty = 1'b1;
    cyc();
    cyc();
    chk("reset_rd_en", fifo_rd_en, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    sys_rst_n = 1'b1;
    cyc();

    // Basic burst with exact cycle timing.
    ready_mode = 0;
    for (int i = 0; i < 5; i++) push(8'(8'h11 + i));
    begin
      int d0;
      d0 = done_cnt;
      start = 1'b1;
      burst_len = 8'd5;
      for (int k = 1; k <= 9; k++) begin
        cyc();
        start = 1'b0;
        chk("basic_rd_en", fifo_rd_en, 32'(k >= 1 && k <= 5));
        chk("basic_out_valid", out_valid, 32'(k >= 3 && k <= 7));
        chk("basic_done", done, 32'(k == 8));
        chk("basic_busy", busy, 32'(k <= 7));
        if (k >= 3 && k <= 7) chk("basic_out_data", out_data, 32'(8'h10 + k - 2));
      end
      chk("basic_done_count", 32'(done_cnt - d0), 1);
      chk("basic_drained", 32'(exp_q.size()), 0);
    end

    // Zero length burst.
    start = 1'b1;
    burst_len = 8'd0;
    cyc();
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_rd_en", fifo_rd_en, 0);
    chk("zero_busy", busy, 0);
    cyc();
    chk("zero_done_gone", done, 0);
    chk("zero_busy_idle", busy, 0);

    // Backpressure 1,0,0 pattern with full preload.
    ready_mode = 1;
    pat_ph = 0;
    run_burst(8, 8, 0, -1);

    // Starved FIFO.
    ready_mode = 0;
    run_burst(3, 0, 10, -1);

    // Start while busy.
    run_burst(6, 6, 0, 4);

    // Mid-burst reset.
    for (int i = 0; i < 10; i++) push(8'($urandom));
    start = 1'b1;
    burst_len = 8'd10;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      start = 1'b0;
    end
    sys_rst_n = 1'b0;
    cyc();
    sys_rst_n = 1'b1;
    fq.delete();
    exp_q.delete();
    rd_cnt  = 0;
    acc_cnt = 0;
    fifo_empty = 1'b1;
    chk("rst_mid_rd_en", fifo_rd_en, 0);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_out_data", out_data, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    cyc();
    run_burst(2, 2, 0, -1);

    // Randomised bursts under random backpressure.
    ready_mode = 2;
    for (int n = 0; n < 10; n++) begin
      int len;
      len = $urandom_range(1, 20);
      run_burst(len, $urandom_range(0, len), $urandom_range(0, 5), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
